// File: rtl/note_write_ctrl.sv
// note_write_ctrl: edge-triggered note RAM writer with fill-level tracking.
// Define NOTE_CLEAR_SWEEP_EN to erase the RAM with a hardware sweep on clear.
module note_write_ctrl #(
  parameter int                ADDR_W      = 6,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write,
  input  logic [DATA_W-1:0] note_in,
  input  logic              clear,
  input  logic              wrap_mode,
  output logic              WE,
  output logic [ADDR_W-1:0] writeDirection,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W:0]   note_count,
  output logic              full,
  output logic              overflow,
  output logic              busy
);
  localparam int                DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   L_C1    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] L_A1    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] L_LAST  = '1;

  logic              r_write_d;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_ovf;

  logic              w_write_d;
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W:0]   w_count;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_ovf;
  logic              w_idle;
  logic              w_edge;
  logic              w_full;
  logic              w_take;

`ifdef NOTE_CLEAR_SWEEP_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  state_t r_state, w_state;
  logic   r_busy, w_busy;
  assign w_idle = (r_state == S_IDLE);
  assign busy   = r_busy;
`else
  assign w_idle = 1'b1;
  assign busy   = 1'b0;
`endif

  assign w_full = (r_count == L_DEPTH);
  assign w_edge = write & ~r_write_d;
  assign w_take = w_edge & (~w_full | wrap_mode);

  always_comb begin
    w_write_d = write;
    w_ptr     = r_ptr;
    w_count   = r_count;
    w_we      = 1'b0;
    w_addr    = r_addr;
    w_data    = r_data;
    w_ovf     = 1'b0;
`ifdef NOTE_CLEAR_SWEEP_EN
    w_state   = r_state;
    w_busy    = r_busy;
`endif
    if (!w_idle) begin
`ifdef NOTE_CLEAR_SWEEP_EN
      // r_addr holds the address just written by the sweep
      if (r_addr == L_LAST) begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_ptr   = '0;
        w_count = '0;
      end else begin
        w_we   = 1'b1;
        w_addr = r_addr + L_A1;
        w_data = CLEAR_VALUE;
      end
`endif
    end else if (clear) begin
`ifdef NOTE_CLEAR_SWEEP_EN
      w_state = S_CLEAR;
      w_busy  = 1'b1;
      w_we    = 1'b1;
      w_addr  = '0;
      w_data  = CLEAR_VALUE;
`else
      w_ptr   = '0;
      w_count = '0;
`endif
    end else if (w_take) begin
      w_we   = 1'b1;
      w_addr = r_ptr;
      w_data = note_in;
      w_ptr  = r_ptr + L_A1;
      if (!w_full) w_count = r_count + L_C1;
    end else if (w_edge) begin
      w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_write_d <= 1'b0;
      r_ptr     <= '0;
      r_count   <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_ovf     <= 1'b0;
`ifdef NOTE_CLEAR_SWEEP_EN
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
`endif
    end else begin
      r_write_d <= w_write_d;
      r_ptr     <= w_ptr;
      r_count   <= w_count;
      r_we      <= w_we;
      r_addr    <= w_addr;
      r_data    <= w_data;
      r_ovf     <= w_ovf;
`ifdef NOTE_CLEAR_SWEEP_EN
      r_state   <= w_state;
      r_busy    <= w_busy;
`endif
    end
  end

  assign WE             = r_we;
  assign writeDirection = r_addr;
  assign write_data     = r_data;
  assign note_count     = r_count;
  assign full           = w_full;
  assign overflow       = r_ovf;
endmodule

// File: doc/note_write_ctrl.md
# note_write_ctrl

- Parametrised write-side controller for the note memory. Converts rising edges of the `write` strobe into single-cycle `WE` pulses, each with a registered address and latched note value.
- Tracks fill level, and in stop mode saturates at memory depth; in wrap mode it overwrites circularly.
- Optionally erases the whole memory with a hardware sweep.
- Sits between the keypad/note-decoder logic and the note RAM write port, replacing the fixed 6-bit single-mode writer.

## Interface
Parameters:
- `ADDR_W`, 6, address width; depth `DEPTH = 2**ADDR_W`.
- `DATA_W`, 8, note word width.
- `CLEAR_VALUE`, 0, word written during an erase sweep (DATA_W bits).

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `write`  in  1  note write request; level input, rising edge acts.
- `note_in`  in  DATA_W  note to store, sampled on the request edge cycle.
- `clear`  in  1  erase request, level-sampled.
- `wrap_mode`  in  1  1 = circular overwrite when full, 0 = stop when full.
- `WE`  out  1  RAM write enable, one-cycle pulse.
- `writeDirection`  out  ADDR_W  RAM write address, valid while `WE`=1.
- `write_data`  out  DATA_W  RAM write data, valid while `WE`=1.
- `note_count`  out  ADDR_W+1  number of valid notes, 0..DEPTH.
- `full`  out  1  `note_count == DEPTH`.
- `overflow`  out  1  one-cycle pulse for a request dropped in stop mode.
- `busy`  out  1  erase sweep in progress.

## Operation
- Internal regs: `write_d` (previous `write`), `ptr` (ADDR_W, next address), state {IDLE, CLEAR}.
- Request edge: `write`=1 and `write_d`=0 in the same cycle. A `write` held high entering the first post-reset cycle counts as an edge, because `write_d` resets to 0.
- IDLE, edge, `full`=0:
  - next cycle: `WE`=1, `writeDirection`=`ptr`, `write_data`=`note_in`.
  - `ptr`+1 (mod DEPTH); `note_count`+1.
- IDLE, edge, `full`=1, `wrap_mode`=1:
  - same write at `ptr`, oldest note overwritten.
  - `ptr`+1 mod DEPTH; `note_count` stays DEPTH.
- IDLE, edge, `full`=1, `wrap_mode`=0:
  - no write; `overflow`=1 for one cycle.
  - `ptr` and `note_count` unchanged.
- `clear`=1 in IDLE: enter CLEAR (sweep behaviour defined under Configuration).
- `clear` and a request edge in the same cycle: clear wins; the request is dropped silently, with no `overflow`.
- In CLEAR:
  - request edges and `clear` are ignored.
  - `write_d` keeps tracking `write`, so a level held across the sweep does not fire afterwards.
- `WE` is never high on two consecutive cycles in IDLE, because edges need `write` low for at least one cycle.
- `ptr` wraps from DEPTH-1 to 0 in both modes.
- `note_count` never exceeds DEPTH.
- `full` is combinational from `note_count`; all other outputs are registered.

## Timing
- Reset values: `WE`=0, `writeDirection`=0, `write_data`=0, `note_count`=0, `full`=0, `overflow`=0, `busy`=0, `ptr`=0, `write_d`=0, state IDLE.
- Latency: request edge in cycle N gives `WE` high in cycle N+1 only. `note_count`/`full` update is visible in N+1.
- Maximum write rate: one note per 2 cycles.
- `overflow` is asserted in cycle N+1 for an edge in cycle N.
- Reset mid-sweep: the sweep aborts immediately and all registers take their reset values. Partially erased RAM is acceptable.

## Configuration
- `NOTE_CLEAR_SWEEP_EN` defined:
  - CLEAR lasts exactly DEPTH cycles, writing `CLEAR_VALUE` to addresses 0..DEPTH-1 in order with `WE`=1 every cycle.
  - `busy`=1 throughout.
  - On the cycle after the last write: IDLE, `ptr`=0, `note_count`=0, `busy`=0.
- Not defined:
  - `clear` resets `ptr`=0 and `note_count`=0 on the next cycle; no RAM writes are issued.
  - `busy` is tied 0; the CLEAR state is absent.

## Test plan
- ADDR_W=2, stop mode:
  - Stimulus: 5 request edges with notes 0x11,0x22,0x33,0x44,0x55.
  - Response: `WE` pulses at addresses 0,1,2,3 with those data; `full`=1 after the 4th; 5th gives `overflow` pulse, no `WE`, count stays 4.
- ADDR_W=2, wrap mode:
  - Stimulus: 6 edges with notes 1..6.
  - Response: writes at 0,1,2,3,0,1 with data 1..6; `note_count` saturates at 4; `overflow` never asserted.
- Edge detect:
  - Stimulus: `write` held high for 10 cycles.
  - Response: exactly one `WE`, one cycle after the rise. Re-rise after one low cycle gives a second `WE`.
- Sweep (macro on, ADDR_W=2, CLEAR_VALUE=0):
  - Stimulus: after 3 notes, pulse `clear`.
  - Response: `busy` high for 4 cycles; `WE` with addresses 0,1,2,3 and data 0; then count 0. The next note is written at address 0.
- Simultaneous events:
  - Stimulus: `clear` and a `write` edge in the same cycle.
  - Response: no note write; sweep/clear occurs.
- Reset mid-sweep:
  - Stimulus: `reset` asserted mid-sweep.
  - Response: all outputs at reset values the following cycle.
